// File: rtl/crtc_prog_seq_pkg.sv
// -----------------------------------------------------------------------------
// crtc_prog_seq_pkg
// Shared definitions for the CRTC register-programming sequencer:
//   - FSM state encodings (3-bit localparams)
//   - number of CRTC data registers replayed from an image
//   - CRTC host-bus bundle type and its idle (no access) value
//   - helper that formats a register index as a select-write data byte
// -----------------------------------------------------------------------------
package crtc_prog_seq_pkg;

    localparam int CRTC_NREGS = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_SEL   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_FINAL = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // One CRTC host-bus access as seen on the ENABLE/nCS/R_nW/RS/DI pins.
    typedef struct packed {
        logic       en;
        logic       ncs;
        logic       rnw;
        logic       rs;
        logic [7:0] di;
    } crtc_bus_t;

    // Bus value with no access in progress.
    localparam crtc_bus_t BUS_IDLE = '{en: 1'b0, ncs: 1'b1, rnw: 1'b1, rs: 1'b0, di: 8'h00};

    // Address-register write data: the CRTC only decodes the low 5 bits.
    function automatic logic [7:0] sel_byte(input logic [4:0] addr);
        return {3'b000, addr};
    endfunction

endpackage

// File: rtl/crtc_prog_seq.sv
// -----------------------------------------------------------------------------
// crtc_prog_seq
// Owns the UM6845R CRTC host bus. While idle, CPU accesses pass straight
// through. On load_start it fetches a 17-byte image (byte 0 = selected address
// register, bytes 1..NREGS = R0..R(NREGS-1)) and replays it as timed
// select/data write strobes, then re-selects the saved address so the CPU sees
// the address latch it expects. The CPU is stalled (cpu_wait) meanwhile.
//
// Ports:
//   CLOCK, nRESET          system clock, synchronous active-low reset
//   CLKEN                  CRTC bus-rate enable; loader strobes only on CLKEN
//   cpu_en/ncs/rnw/rs/di   CPU bus request (CRTC pin semantics)
//   cpu_wait               CPU must hold its access while high
//   load_start             one-cycle pulse starting an image load
//   img_valid/img_data     image byte stream in; img_ready = byte accepted
//   busy, done             load in progress / one-cycle completion pulse
//   crtc_en/ncs/rnw/rs/di  CRTC pin drive
// -----------------------------------------------------------------------------
module crtc_prog_seq
    import crtc_prog_seq_pkg::*;
#(
    parameter int NREGS = CRTC_NREGS
) (
    input  logic       CLOCK,
    input  logic       nRESET,
    input  logic       CLKEN,
    input  logic       cpu_en,
    input  logic       cpu_ncs,
    input  logic       cpu_rnw,
    input  logic       cpu_rs,
    input  logic [7:0] cpu_di,
    output logic       cpu_wait,
    input  logic       load_start,
    input  logic       img_valid,
    input  logic [7:0] img_data,
    output logic       img_ready,
    output logic       busy,
    output logic       done,
    output logic       crtc_en,
    output logic       crtc_ncs,
    output logic       crtc_rnw,
    output logic       crtc_rs,
    output logic [7:0] crtc_di
);

    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    logic [2:0] state_q,    state_d;
    logic [4:0] idx_q,      idx_d;
    logic       first_q,    first_d;
    logic [7:0] val_q,      val_d;
    logic [4:0] sel_save_q, sel_save_d;
    logic [7:0] di_q,       di_d;     // last value placed on crtc_di

    crtc_bus_t  bus_s;

    // Next-state logic for the sequencer FSM and its datapath registers.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        first_d    = first_q;
        val_d      = val_q;
        sel_save_d = sel_save_q;
        di_d       = di_q;
        case (state_q)
            ST_IDLE: begin
                // Track the passthrough data so the pin holds it once a load starts.
                di_d = cpu_di;
                if (load_start) begin
                    state_d = ST_FETCH;
                    idx_d   = 5'd0;
                    first_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (img_valid) begin
                    if (first_q) begin
                        sel_save_d = img_data[4:0];
                        first_d    = 1'b0;
                    end else begin
                        val_d   = img_data;
                        state_d = ST_SEL;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_SEL: begin
                if (CLKEN) begin
                    di_d    = sel_byte(idx_q);
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_SEL;
                end
            end
            ST_DATA: begin
                if (CLKEN) begin
                    di_d = val_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FINAL;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_FINAL: begin
                if (CLKEN) begin
                    di_d    = sel_byte(sel_save_q);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FINAL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // CRTC bus mux: passthrough when idle, one-cycle strobes from the loader.
    // Reset forces the idle bus so an aborted load cannot emit a strobe.
    always_comb begin
        bus_s    = BUS_IDLE;
        bus_s.di = di_q;
        if (!nRESET) begin
            bus_s = BUS_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bus_s = '{en: cpu_en, ncs: cpu_ncs, rnw: cpu_rnw, rs: cpu_rs, di: cpu_di};
                end
                ST_SEL: begin
                    if (CLKEN) begin
                        bus_s = '{en: 1'b1, ncs: 1'b0, rnw: 1'b0, rs: 1'b0, di: sel_byte(idx_q)};
                    end else begin
                        bus_s.di = di_q;
                    end
                end
                ST_DATA: begin
                    if (CLKEN) begin
                        bus_s = '{en: 1'b1, ncs: 1'b0, rnw: 1'b0, rs: 1'b1, di: val_q};
                    end else begin
                        bus_s.di = di_q;
                    end
                end
                ST_FINAL: begin
                    if (CLKEN) begin
                        bus_s = '{en: 1'b1, ncs: 1'b0, rnw: 1'b0, rs: 1'b0, di: sel_byte(sel_save_q)};
                    end else begin
                        bus_s.di = di_q;
                    end
                end
                default: begin
                    bus_s.di = di_q;
                end
            endcase
        end
    end

    assign crtc_en   = bus_s.en;
    assign crtc_ncs  = bus_s.ncs;
    assign crtc_rnw  = bus_s.rnw;
    assign crtc_rs   = bus_s.rs;
    assign crtc_di   = bus_s.di;

    assign busy      = nRESET && (state_q != ST_IDLE);
    assign cpu_wait  = busy;
    assign img_ready = nRESET && (state_q == ST_FETCH);
    assign done      = nRESET && (state_q == ST_DONE);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            state_q    <= ST_IDLE;
            idx_q      <= 5'd0;
            first_q    <= 1'b0;
            val_q      <= 8'h00;
            sel_save_q <= 5'd0;
            di_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            first_q    <= first_d;
            val_q      <= val_d;
            sel_save_q <= sel_save_d;
            di_q       <= di_d;
        end
    end

endmodule

// File: tb/tb_crtc_prog_seq.sv
// -----------------------------------------------------------------------------
// tb_crtc_prog_seq
// Directed bench for crtc_prog_seq. A small CRTC model latches the address and
// data registers from the DUT pins; every pin strobe is logged with its cycle
// so the replay order, timing and register contents can be checked against
// hand-built image tables.
// -----------------------------------------------------------------------------
module tb_crtc_prog_seq;

    logic       CLOCK = 1'b0;
    logic       nRESET;
    logic       CLKEN = 1'b1;
    logic       cpu_en, cpu_ncs, cpu_rnw, cpu_rs;
    logic [7:0] cpu_di;
    logic       cpu_wait;
    logic       load_start;
    logic       img_valid = 1'b1;
    logic [7:0] img_data;
    logic       img_ready, busy, done;
    logic       crtc_en, crtc_ncs, crtc_rnw, crtc_rs;
    logic [7:0] crtc_di;

    int errors = 0;
    int checks = 0;

    crtc_prog_seq #(.NREGS(16)) dut (
        .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN),
        .cpu_en(cpu_en), .cpu_ncs(cpu_ncs), .cpu_rnw(cpu_rnw), .cpu_rs(cpu_rs),
        .cpu_di(cpu_di), .cpu_wait(cpu_wait), .load_start(load_start),
        .img_valid(img_valid), .img_data(img_data), .img_ready(img_ready),
        .busy(busy), .done(done),
        .crtc_en(crtc_en), .crtc_ncs(crtc_ncs), .crtc_rnw(crtc_rnw),
        .crtc_rs(crtc_rs), .crtc_di(crtc_di)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic       rs;
        logic [7:0] di;
        int         cyc;
    } strobe_t;

    strobe_t    ld_q[$];
    strobe_t    cpu_q[$];
    logic [7:0] crtc_regs [32];
    logic [4:0] crtc_addr;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         viol = 0;
    int         c0 = 0;

    // CRTC model and strobe logger.
    always @(posedge CLOCK) begin
        cyc <= cyc + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (crtc_en && !crtc_ncs && !crtc_rnw) begin
            if (crtc_rs) crtc_regs[crtc_addr] <= crtc_di;
            else         crtc_addr <= crtc_di[4:0];
            if (busy) begin
                ld_q.push_back('{rs: crtc_rs, di: crtc_di, cyc: cyc});
                if (!CLKEN) viol <= viol + 1;
            end else begin
                cpu_q.push_back('{rs: crtc_rs, di: crtc_di, cyc: cyc});
            end
        end
    end

    // Image byte source.
    logic [7:0] img  [17];
    logic [7:0] img_a[17];
    int         ptr = 0;
    logic       ptr_clr = 1'b0;

    // Advance the image pointer on each accepted byte.
    always @(posedge CLOCK) begin
        if (ptr_clr) ptr <= 0;
        else if (img_valid && img_ready) ptr <= ptr + 1;
    end

    // Present the current image byte.
    always_comb begin
        if (ptr < 17) img_data = img[ptr];
        else          img_data = 8'h00;
    end

    // CLKEN and img_valid pacing.
    int clk_mode = 0;
    int gap_mode = 0;
    int div = 0;
    always @(negedge CLOCK) begin
        div = div + 1;
        if (clk_mode == 0) CLKEN = 1'b1;
        else               CLKEN = (div % 4 == 0) ? 1'b1 : 1'b0;
        if (gap_mode == 0) img_valid = 1'b1;
        else               img_valid = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
    end

    task automatic cpu_idle();
        cpu_en = 1'b0; cpu_ncs = 1'b1; cpu_rnw = 1'b1; cpu_rs = 1'b0; cpu_di = 8'h00;
    endtask

    task automatic start_load(input bit with_cpu);
        @(negedge CLOCK);
        ptr_clr = 1'b1;
        load_start = 1'b1;
        c0 = cyc;
        if (with_cpu) begin
            cpu_en = 1'b1; cpu_ncs = 1'b0; cpu_rnw = 1'b0; cpu_rs = 1'b0; cpu_di = 8'h03;
            #1;
            checks++;
            if ({crtc_en, crtc_ncs, crtc_rnw, crtc_rs, crtc_di, busy} !== {4'b1000, 8'h03, 1'b0}) begin
                errors++;
                $display("FAIL start_cpu_pass: got en=%b ncs=%b rnw=%b rs=%b di=%h busy=%b expected 1 0 0 0 03 busy=0",
                         crtc_en, crtc_ncs, crtc_rnw, crtc_rs, crtc_di, busy);
            end
        end
        @(negedge CLOCK);
        load_start = 1'b0;
        ptr_clr = 1'b0;
        cpu_idle();
        if (with_cpu) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL start_busy_rise: got %b expected 1", busy);
            end
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_cnt;
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK);
            if (done_cnt != d0) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s done_timeout: got no done within %0d cycles expected done", name, budget);
        end
    endtask

    task automatic check_seq(input int base, input string name);
        logic       exp_rs;
        logic [7:0] exp_di;
        checks++;
        if (ld_q.size() != base + 33) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d expected 33", name, ld_q.size() - base);
        end
        for (int j = 0; j < 33; j++) begin
            if (base + j >= ld_q.size()) break;
            if (j == 32) begin
                exp_rs = 1'b0; exp_di = {3'b000, img[0][4:0]};
            end else if (j % 2 == 0) begin
                exp_rs = 1'b0; exp_di = 8'(j / 2);
            end else begin
                exp_rs = 1'b1; exp_di = img[j / 2 + 1];
            end
            checks++;
            if (ld_q[base + j].rs !== exp_rs || ld_q[base + j].di !== exp_di) begin
                errors++;
                $display("FAIL %s strobe%0d: got rs=%b di=%h expected rs=%b di=%h",
                         name, j, ld_q[base + j].rs, ld_q[base + j].di, exp_rs, exp_di);
            end
        end
    endtask

    task automatic check_regs(input string name);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (crtc_regs[k] !== img[k + 1]) begin
                errors++;
                $display("FAIL %s R%0d: got %h expected %h", name, k, crtc_regs[k], img[k + 1]);
            end
        end
        checks++;
        if (crtc_addr !== img[0][4:0]) begin
            errors++;
            $display("FAIL %s addr_latch: got %h expected %h", name, crtc_addr, img[0][4:0]);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({crtc_en, crtc_ncs, crtc_rnw, crtc_rs, crtc_di, img_ready, busy, done, cpu_wait} !== 16'h6000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 6000",
                     {crtc_en, crtc_ncs, crtc_rnw, crtc_rs, crtc_di, img_ready, busy, done, cpu_wait});
        end
        @(negedge CLOCK);
        nRESET = 1'b1;
        #1;
        checks++;
        if ({img_ready, busy, done, cpu_wait} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: got %b expected 0000", {img_ready, busy, done, cpu_wait});
        end
    endtask

    task automatic test_passthrough();
        logic [11:0] vec [4];
        vec[0] = {4'b1000, 8'h07};
        vec[1] = {4'b1001, 8'h1E};
        vec[2] = {4'b1011, 8'h00};
        vec[3] = {4'b0110, 8'h00};
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK);
            {cpu_en, cpu_ncs, cpu_rnw, cpu_rs, cpu_di} = vec[i];
            #1;
            checks++;
            if ({crtc_en, crtc_ncs, crtc_rnw, crtc_rs, crtc_di, busy, cpu_wait} !== {vec[i], 2'b00}) begin
                errors++;
                $display("FAIL passthrough%0d: got %h expected %h", i,
                         {crtc_en, crtc_ncs, crtc_rnw, crtc_rs, crtc_di, busy, cpu_wait}, {vec[i], 2'b00});
            end
        end
        cpu_idle();
        @(negedge CLOCK);
        checks++;
        if (crtc_regs[7] !== 8'h1E) begin
            errors++;
            $display("FAIL passthrough_R7: got %h expected 1e", crtc_regs[7]);
        end
    endtask

    task automatic test_full_load();
        int base = ld_q.size();
        start_load(1'b0);
        wait_done(200, "full");
        checks++;
        if (done_cyc - c0 != 51) begin
            errors++;
            $display("FAIL full_done_cycle: got %0d expected 51", done_cyc - c0);
        end
        check_seq(base, "full");
        if (ld_q.size() == base + 33) begin
            checks++;
            if (ld_q[base].cyc - c0 != 3 || ld_q[base + 32].cyc - c0 != 50) begin
                errors++;
                $display("FAIL full_strobe_timing: got first=%0d final=%0d expected 3 50",
                         ld_q[base].cyc - c0, ld_q[base + 32].cyc - c0);
            end
        end
        check_regs("full");
    endtask

    task automatic test_throttle();
        int base = ld_q.size();
        int v0 = viol;
        clk_mode = 1;
        start_load(1'b0);
        wait_done(2000, "throttle");
        clk_mode = 0;
        checks++;
        if (viol != v0) begin
            errors++;
            $display("FAIL throttle_clken: got %0d strobes on CLKEN=0 expected 0", viol - v0);
        end
        check_seq(base, "throttle");
        check_regs("throttle");
    endtask

    task automatic test_gaps();
        int base = ld_q.size();
        gap_mode = 1;
        start_load(1'b0);
        wait_done(2000, "gaps");
        gap_mode = 0;
        check_seq(base, "gaps");
    endtask

    task automatic test_reset_mid_load();
        int  base;
        int  d0;
        bit  hit = 1'b0;
        img[0] = 8'h09;
        for (int k = 0; k < 16; k++) img[k + 1] = 8'h40 + 8'(k);
        base = ld_q.size();
        d0 = done_cnt;
        start_load(1'b0);
        for (int i = 0; i < 200; i++) begin
            if (ld_q.size() >= base + 12) begin
                hit = 1'b1;
                break;
            end
            @(negedge CLOCK);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_reach: got %0d strobes expected 12", ld_q.size() - base);
        end
        nRESET = 1'b0;
        #1;
        checks++;
        if ({crtc_en, crtc_ncs, crtc_rnw, crtc_rs, busy, cpu_wait, img_ready} !== 7'b0110000) begin
            errors++;
            $display("FAIL rst_mid_bus: got %b expected 0110000",
                     {crtc_en, crtc_ncs, crtc_rnw, crtc_rs, busy, cpu_wait, img_ready});
        end
        @(negedge CLOCK);
        nRESET = 1'b1;
        #1;
        checks++;
        if ({crtc_en, crtc_ncs, crtc_rnw, crtc_rs, busy} !== 5'b01100) begin
            errors++;
            $display("FAIL rst_mid_after: got %b expected 01100", {crtc_en, crtc_ncs, crtc_rnw, crtc_rs, busy});
        end
        repeat (10) @(negedge CLOCK);
        checks++;
        if (ld_q.size() != base + 12 || done_cnt != d0) begin
            errors++;
            $display("FAIL rst_mid_no_more: got strobes=%0d dones=%0d expected 12 0", ld_q.size() - base, done_cnt - d0);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (crtc_regs[k] !== ((k < 6) ? img[k + 1] : img_a[k + 1])) begin
                errors++;
                $display("FAIL rst_mid_R%0d: got %h expected %h", k, crtc_regs[k],
                         (k < 6) ? img[k + 1] : img_a[k + 1]);
            end
        end
    endtask

    task automatic test_edge();
        int base;
        int d0;
        for (int k = 0; k < 17; k++) img[k] = img_a[k];
        img[0] = 8'hFF;
        base = ld_q.size();
        d0 = done_cnt;
        start_load(1'b1);
        repeat (15) @(negedge CLOCK);
        load_start = 1'b1;
        @(negedge CLOCK);
        load_start = 1'b0;
        wait_done(200, "edge");
        check_seq(base, "edge");
        if (ld_q.size() == base + 33) begin
            checks++;
            if (ld_q[base + 32].di !== 8'h1F) begin
                errors++;
                $display("FAIL edge_final_sel: got %h expected 1f", ld_q[base + 32].di);
            end
        end
        repeat (6) @(negedge CLOCK);
        checks++;
        if (busy !== 1'b0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL edge_busy_ignored: got busy=%b dones=%0d expected 0 1", busy, done_cnt - d0);
        end
    endtask

    task automatic test_cpu_stall();
        int base;
        int cb;
        int d0;
        int badw = 0;
        int waits = 0;
        for (int k = 0; k < 17; k++) img[k] = img_a[k];
        base = ld_q.size();
        start_load(1'b0);
        cb = cpu_q.size();
        d0 = done_cnt;
        cpu_en = 1'b1; cpu_ncs = 1'b0; cpu_rnw = 1'b0; cpu_rs = 1'b1; cpu_di = 8'hAA;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLOCK);
            if (done_cnt != d0) break;
            if (busy) begin
                if (cpu_wait !== 1'b1) badw++;
                else waits++;
            end
        end
        checks++;
        if (badw != 0 || waits < 40) begin
            errors++;
            $display("FAIL stall_wait: got bad=%0d high=%0d expected 0 >=40", badw, waits);
        end
        checks++;
        if (cpu_q.size() != cb) begin
            errors++;
            $display("FAIL stall_no_cpu_strobe: got %0d expected 0", cpu_q.size() - cb);
        end
        check_seq(base, "stall");
        #1;
        checks++;
        if (crtc_en !== 1'b1 || crtc_di !== 8'hAA || cpu_wait !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got en=%b di=%h wait=%b expected 1 aa 0", crtc_en, crtc_di, cpu_wait);
        end
        @(negedge CLOCK);
        cpu_idle();
        checks++;
        if (cpu_q.size() != cb + 1) begin
            errors++;
            $display("FAIL stall_cpu_after: got %0d cpu strobes expected 1", cpu_q.size() - cb);
        end else if (cpu_q[cb].di !== 8'hAA || cpu_q[cb].rs !== 1'b1) begin
            errors++;
            $display("FAIL stall_cpu_after: got rs=%b di=%h expected 1 aa", cpu_q[cb].rs, cpu_q[cb].di);
        end
    endtask

    initial begin
        img_a[0]  = 8'h0C; img_a[1]  = 8'h3F; img_a[2]  = 8'h28; img_a[3]  = 8'h2E;
        img_a[4]  = 8'h8E; img_a[5]  = 8'h26; img_a[6]  = 8'h00; img_a[7]  = 8'h19;
        img_a[8]  = 8'h1E; img_a[9]  = 8'h00; img_a[10] = 8'h07; img_a[11] = 8'h00;
        img_a[12] = 8'h00; img_a[13] = 8'h30; img_a[14] = 8'h00; img_a[15] = 8'h00;
        img_a[16] = 8'h00;
        for (int k = 0; k < 17; k++) img[k] = img_a[k];
        nRESET = 1'b0;
        load_start = 1'b0;
        cpu_idle();
        repeat (3) @(negedge CLOCK);
        test_reset();
        test_passthrough();
        test_full_load();
        test_throttle();
        test_gaps();
        check_regs("gaps");
        test_reset_mid_load();
        test_edge();
        test_cpu_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crtc_prog_seq.md
# crtc_prog_seq

Register-programming sequencer for the UM6845R CRTC. It owns the CRTC host bus: it passes CPU accesses through when idle, and it replays a 17-byte register image (selected index plus R0–R15) as a timed sequence of select/data writes. The image comes from snapshot load or an OSD preset. It sits between the Z80 I/O decode and the CRTC, and stalls the CPU while a load is in progress.

## Interface
Parameters:
- NREGS, 16, number of data registers replayed (R0..NREGS-1).

Ports:
- CLOCK  in  1  system clock.
- nRESET  in  1  reset; **synchronous, active-low**.
- CLKEN  in  1  CRTC bus-rate enable. Loader strobes occur only on CLKEN cycles.
- cpu_en, cpu_ncs, cpu_rnw, cpu_rs  in  1 each  CPU bus request, same meaning as the CRTC ENABLE/nCS/R_nW/RS pins.
- cpu_di  in  8  CPU write data.
- cpu_wait  out  1  high while the loader is busy. CPU accesses made while it is high are ignored, and the CPU must hold them.
- load_start  in  1  single-cycle pulse that starts an image load.
- img_valid  in  1  image byte available.
- img_data  in  8  image byte.
- img_ready  out  1  sequencer accepts img_data this cycle.
- busy  out  1  load in progress.
- done  out  1  single-cycle pulse when a load completes.
- crtc_en, crtc_ncs, crtc_rnw, crtc_rs  out  1 each  drive the CRTC ENABLE, nCS, R_nW and RS pins.
- crtc_di  out  8  drives the CRTC DI pin.

## Operation
- States: IDLE, FETCH, SEL, DATA, FINAL, DONE.
- IDLE:
  - crtc_* equals cpu_* combinationally.
  - busy = 0, cpu_wait = 0.
  - load_start moves to FETCH with idx = 0 and first = 1.
- FETCH:
  - img_ready = 1. The byte transfers on img_valid & img_ready.
  - If first = 1: the byte's low 5 bits go to sel_save, first clears, and the state stays FETCH.
  - Otherwise: the byte goes to val and the state moves to SEL.
- SEL: on a CLKEN cycle, issue a one-cycle write with crtc_en = 1, crtc_ncs = 0, crtc_rnw = 0, crtc_rs = 0, crtc_di = {3'b0, idx}, then move to DATA.
- DATA:
  - On a CLKEN cycle, issue a write with crtc_rs = 1 and crtc_di = val.
  - If idx = NREGS-1, move to FINAL. Otherwise increment idx and return to FETCH.
- FINAL: on a CLKEN cycle, issue a select write with crtc_di = {3'b0, sel_save}, then move to DONE. This restores the CPU-visible address latch.
- DONE: done = 1 for one cycle, then IDLE.
- Bus idle value outside strobes (non-IDLE states): crtc_en = 0, crtc_ncs = 1, crtc_rnw = 1, crtc_rs = 0, crtc_di holds its last value.
- Strobes are exactly one CLOCK cycle wide. The CRTC latches on every enabled CLOCK edge.
- busy = 1 and cpu_wait = 1 in every state except IDLE.
- idx is 5 bits and never wraps. sel_save keeps only bits [4:0].

## Timing
- Reset values:
  - State IDLE.
  - crtc_en = 0, crtc_ncs = 1, crtc_rnw = 1, crtc_rs = 0, crtc_di = 0.
  - img_ready = 0, busy = 0, done = 0, cpu_wait = 0.
  - idx = 0, sel_save = 0.
- Reset in any state aborts the load. No further strobes follow, and CRTC registers already written keep their values.
- load_start coinciding with a CPU access: the CPU access passes through that cycle, and busy rises the next cycle.
- load_start while busy is ignored.
- With CLKEN held at 1 and img_valid held at 1:
  - byte0 is accepted at cycle 1.
  - For register k: byte k+1 at cycle 3k+2, SEL at 3k+3, DATA at 3k+4.
  - FINAL at cycle 3·NREGS+2, done at 3·NREGS+3.
- img_valid low stalls in FETCH indefinitely. CLKEN low stalls SEL, DATA and FINAL without emitting a strobe.

## Structure
- The shared package holds the state encoding localparams, the CRTC register count (16), and the idle bus-value constants.
- No sub-module. This is a single FSM plus the idx, val and sel_save registers and the output mux.

## Test plan
- Idle passthrough: CPU select 0x07, then data 0x1E → crtc_* mirrors cpu_* cycle for cycle; busy = 0.
- Full load: image {0x0C, 0x3F, 0x28, 0x2E, 0x8E, 0x26, 0x00, 0x19, 0x1E, 0x00, 0x07, 0, 0, 0x30, 0x00, 0, 0} with CLKEN = 1:
  - 33 strobes, in the order select 0, data 0x3F, …, select 15, data 0, select 0x0C.
  - done at cycle 51.
  - CRTC model registers match the image.
- Throttling:
  - CLKEN = 1 one cycle in 4: no strobe falls on a CLKEN = 0 cycle.
  - Random img_valid gaps: strobe order is unchanged.
- CPU stall: a CPU write during the load → cpu_wait = 1, and no CPU strobe reaches the CRTC until after done.
- Reset mid-load: nRESET asserted after the register-5 data write → the next cycle shows idle bus values, busy = 0, and R0–R5 are written while R6–R15 keep their old values.
- Edge cases:
  - load_start while busy is ignored.
  - byte0 = 0xFF gives a final select of 0x1F.
